alu_exec_unit: RTL

Parametrised successor to the single-cycle ALU control decode: merges ALU-control decoding with a registered ALU datapath behind a valid/ready handshake.
Single-cycle ops return one cycle after acceptance. MUL runs on an iterative shift-add sequencer.
Sits in the EX stage between the register-file/immediate operand muxes and the MEM/writeback path. Lets the core stall on multi-cycle ops.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_ctrl_decode.sv | 57 +++++
 rtl/alu_exec_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: control codes, AluOp classes, FSM states.
package alu_pkg;

    // Decoded ALU control codes
    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_SLL     = 4'b0011;
    localparam logic [3:0] CTRL_XOR     = 4'b0100;
    localparam logic [3:0] CTRL_SRL     = 4'b0101;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_SLT     = 4'b0111;
    localparam logic [3:0] CTRL_SRA     = 4'b1000;
    localparam logic [3:0] CTRL_SLTU    = 4'b1001;
    localparam logic [3:0] CTRL_MUL     = 4'b1010;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    // AluOp classes coming from the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // Funct7 patterns that select operation variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_BUSY = 2'b01,
        DONE     = 2'b10
    } ExecState;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: {AluOp, Funct7, Funct3} -> 4-bit control code.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int MUL_EN = 1
) (
    input  logic [1:0] AluOp,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    output logic [3:0] AluCtrl
);

    // Anything not explicitly matched falls through to ILLEGAL
    always_comb begin
        AluCtrl = CTRL_ILLEGAL;
        case (AluOp)
            ALUOP_MEM:    AluCtrl = CTRL_ADD;
            ALUOP_BRANCH: AluCtrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                if (Funct7 == F7_BASE) begin
                    case (Funct3)
                        3'b000:  AluCtrl = CTRL_ADD;
                        3'b001:  AluCtrl = CTRL_SLL;
                        3'b010:  AluCtrl = CTRL_SLT;
                        3'b011:  AluCtrl = CTRL_SLTU;
                        3'b100:  AluCtrl = CTRL_XOR;
                        3'b101:  AluCtrl = CTRL_SRL;
                        3'b110:  AluCtrl = CTRL_OR;
                        default: AluCtrl = CTRL_AND;
                    endcase
                end else if (Funct7 == F7_ALT) begin
                    if (Funct3 == 3'b000)      AluCtrl = CTRL_SUB;
                    else if (Funct3 == 3'b101) AluCtrl = CTRL_SRA;
                end else if (Funct7 == F7_MULDIV && Funct3 == 3'b000 && MUL_EN != 0) begin
                    AluCtrl = CTRL_MUL;
                end
            end
            default: begin
                // I-type: Funct7 only qualifies the shift encodings
                case (Funct3)
                    3'b000: AluCtrl = CTRL_ADD;
                    3'b001: if (Funct7 == F7_BASE) AluCtrl = CTRL_SLL;
                    3'b010: AluCtrl = CTRL_SLT;
                    3'b011: AluCtrl = CTRL_SLTU;
                    3'b100: AluCtrl = CTRL_XOR;
                    3'b101: begin
                        if (Funct7 == F7_BASE)     AluCtrl = CTRL_SRL;
                        else if (Funct7 == F7_ALT) AluCtrl = CTRL_SRA;
                    end
                    3'b110:  AluCtrl = CTRL_OR;
                    default: AluCtrl = CTRL_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decode + registered single-cycle datapath + iterative shift-add MUL,
// behind valid/ready handshakes on both sides.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       AluOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] AluResult,
    output logic             Zero,
    output logic [3:0]       AluCtrl,
    output logic             IllegalOp
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = $clog2(WIDTH);

    ExecState         state, stateNext;
    logic [3:0]       decCtrl;
    logic             accept, isMul, mulLast;
    logic [WIDTH-1:0] aluNext, mulStep;
    logic [SH_W-1:0]  shamt;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] acc, multiplicand, multiplier;

    alu_ctrl_decode #(.MUL_EN(MUL_EN)) uDecode (
        .AluOp   (AluOp),
        .Funct7  (Funct7),
        .Funct3  (Funct3),
        .AluCtrl (decCtrl)
    );

    // In DONE a new op may enter in the same cycle the held result leaves
    assign InReady  = (state == IDLE) || (state == DONE && OutReady);
    assign accept   = InValid && InReady;
    assign isMul    = (decCtrl == CTRL_MUL);
    assign OutValid = (state == DONE);
    assign Zero     = (AluResult == '0);
    assign mulLast  = (counter == CNT_W'(WIDTH - 1));
    assign shamt    = OperandB[SH_W-1:0];
    assign mulStep  = acc + (multiplier[0] ? multiplicand : '0);

    // Single-cycle result; MUL and ILLEGAL produce zero here
    always_comb begin
        aluNext = '0;
        case (decCtrl)
            CTRL_AND:  aluNext = OperandA & OperandB;
            CTRL_OR:   aluNext = OperandA | OperandB;
            CTRL_ADD:  aluNext = OperandA + OperandB;
            CTRL_SLL:  aluNext = OperandA << shamt;
            CTRL_XOR:  aluNext = OperandA ^ OperandB;
            CTRL_SRL:  aluNext = OperandA >> shamt;
            CTRL_SUB:  aluNext = OperandA - OperandB;
            CTRL_SLT:  aluNext[0] = ($signed(OperandA) < $signed(OperandB));
            CTRL_SRA:  aluNext = $signed(OperandA) >>> shamt;
            CTRL_SLTU: aluNext[0] = (OperandA < OperandB);
            default:   aluNext = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (accept) stateNext = isMul ? MUL_BUSY : DONE;
            MUL_BUSY: if (mulLast) stateNext = DONE;
            DONE: begin
                if (OutReady) begin
                    if (InValid) stateNext = isMul ? MUL_BUSY : DONE;
                    else         stateNext = IDLE;
                end
            end
            default:  stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Result/control registers and the shift-add multiply sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            AluResult    <= '0;
            AluCtrl      <= 4'b0000;
            IllegalOp    <= 1'b0;
            counter      <= '0;
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
        end else if (accept) begin
            AluCtrl   <= decCtrl;
            IllegalOp <= (decCtrl == CTRL_ILLEGAL);
            if (isMul) begin
                counter      <= '0;
                acc          <= '0;
                multiplicand <= OperandA;
                multiplier   <= OperandB;
            end else begin
                AluResult <= aluNext;
            end
        end else if (state == MUL_BUSY) begin
            acc          <= mulStep;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            counter      <= counter + CNT_W'(1);
            if (mulLast) AluResult <= mulStep;
        end
    end

endmodule
